pc_source_sel: RTL

//   Parametrised next-PC selector with a registered PC. Chooses one of NSRC

---
 rtl/pc_source_sel_if.sv | 28 ++
 rtl/pc_source_sel.sv | 126 ++++++++++++
 2 files changed

// File: rtl/pc_source_sel_if.sv
// Bundle of the next-PC request inputs and the registered PC/status outputs
// shared between the control unit (master) and the PC selector (slave).
interface pc_source_sel_if #(
   parameter int WIDTH = 32,
   parameter int NSRC  = 5,
   parameter int SELW  = 3
);
   logic [SELW-1:0]       pc_sel;
   logic [NSRC*WIDTH-1:0] src_flat;
   logic                  pc_write;
   logic                  stall;
   logic                  exc_req;
   logic [WIDTH-1:0]      pc;
   logic [WIDTH-1:0]      epc;
   logic                  pending;
   logic                  sel_err;
   logic                  misalign;

   modport master (
      output pc_sel, src_flat, pc_write, stall, exc_req,
      input  pc, epc, pending, sel_err, misalign
   );

   modport slave (
      input  pc_sel, src_flat, pc_write, stall, exc_req,
      output pc, epc, pending, sel_err, misalign
   );
endinterface

// File: rtl/pc_source_sel.sv
// Registered next-PC selector: picks one of NSRC candidates, buffers one
// redirect across stalls, redirects on exceptions and flags bad requests.
module pc_source_sel #(
   parameter int               WIDTH      = 32,
   parameter int               NSRC       = 5,
   parameter int               SELW       = 3,
   parameter int               ALIGN_BITS = 2,
   parameter logic [WIDTH-1:0] RESET_PC   = 32'h0,
   parameter logic [WIDTH-1:0] EXC_VECTOR = 32'h80000180
) (
   input logic           clk,
   input logic           reset,
   pc_source_sel_if.slave bus
);
   typedef enum logic [0:0] {
      ST_RUN  = 1'b0,
      ST_PEND = 1'b1
   } state_t;

   localparam logic [SELW:0] NSRC_W = NSRC[SELW:0];

   state_t           state_r, state_s;
   logic [WIDTH-1:0] pc_r, pc_s;
   logic [WIDTH-1:0] epc_r, epc_s;
   logic [WIDTH-1:0] pend_pc_r, pend_pc_s;
   logic             sel_err_r, sel_err_s;
   logic             misalign_r, misalign_s;

   logic [WIDTH-1:0] src_arr_s [2**SELW];
   logic [WIDTH-1:0] cand_s;
   logic             sel_ok_s;
   logic             align_ok_s;
   logic             wr_ok_s;

   // Unused select codes read as zero so the mux never indexes past src_flat.
   for (genvar g = 0; g < 2**SELW; g++) begin : g_src
      if (g < NSRC) begin : g_real
         assign src_arr_s[g] = bus.src_flat[g*WIDTH +: WIDTH];
      end else begin : g_pad
         assign src_arr_s[g] = '0;
      end
   end

   assign cand_s   = src_arr_s[bus.pc_sel];
   assign sel_ok_s = ({1'b0, bus.pc_sel} < NSRC_W);

   if (ALIGN_BITS > 0) begin : g_align
      assign align_ok_s = (cand_s[ALIGN_BITS-1:0] == '0);
   end else begin : g_no_align
      assign align_ok_s = 1'b1;
   end

   assign wr_ok_s = bus.pc_write & sel_ok_s & align_ok_s;

   // Next-state, next-PC and error-flag decode; exceptions override redirects.
   always_comb begin
      state_s    = state_r;
      pc_s       = pc_r;
      epc_s      = epc_r;
      pend_pc_s  = pend_pc_r;
      sel_err_s  = bus.pc_write & ~sel_ok_s;
      misalign_s = bus.pc_write & sel_ok_s & ~align_ok_s;
      if (bus.exc_req) begin
         epc_s   = pc_r;
         pc_s    = EXC_VECTOR;
         state_s = ST_RUN;
      end else begin
         case (state_r)
            ST_RUN: begin
               if (wr_ok_s && !bus.stall) begin
                  pc_s = cand_s;
               end else if (wr_ok_s) begin
                  pend_pc_s = cand_s;
                  state_s   = ST_PEND;
               end else begin
                  pc_s = pc_r;
               end
            end
            ST_PEND: begin
               if (bus.stall) begin
                  if (wr_ok_s) begin
                     pend_pc_s = cand_s;
                  end else begin
                     pend_pc_s = pend_pc_r;
                  end
               end else begin
                  state_s = ST_RUN;
                  if (wr_ok_s) begin
                     pc_s = cand_s;
                  end else begin
                     pc_s = pend_pc_r;
                  end
               end
            end
            default: begin
               state_s = ST_RUN;
            end
         endcase
      end
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r    <= ST_RUN;
         pc_r       <= RESET_PC;
         epc_r      <= '0;
         pend_pc_r  <= '0;
         sel_err_r  <= 1'b0;
         misalign_r <= 1'b0;
      end else begin
         state_r    <= state_s;
         pc_r       <= pc_s;
         epc_r      <= epc_s;
         pend_pc_r  <= pend_pc_s;
         sel_err_r  <= sel_err_s;
         misalign_r <= misalign_s;
      end
   end

   assign bus.pc       = pc_r;
   assign bus.epc      = epc_r;
   assign bus.pending  = (state_r == ST_PEND);
   assign bus.sel_err  = sel_err_r;
   assign bus.misalign = misalign_r;
endmodule
